// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider (DIV/DIVU) feeding the Hi/Lo register
//   clk_i, reset_i (async, active-high)
//   start_i, is_signed_i, dividend_i, divisor_i : request, sampled when not busy
//   busy_o        : iteration in progress, new starts ignored
//   done_o        : one-cycle pulse, div_ans_o valid (Hi/Lo write enable)
//   div_ans_o     : {quotient, remainder}, held until the next done
//   div_by_zero_o : divisor was zero for the result on div_ans_o
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               is_signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] div_ans_o,
  output logic               div_by_zero_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     rem_q, dsr_q, shl, diff, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d, dvd_q, q_fix, r_fix, dvd_mag, dsr_mag;
  logic               q_neg_q, r_neg_q, zero_q, busy_q, done_q, dz_q;
  logic [2*WIDTH-1:0] ans_q;
  assign dvd_mag = is_signed_i && dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign dsr_mag = is_signed_i && divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
  // {rem,quo} shifted left as one register; the quotient shifts in from the dividend's LSB end
  assign shl   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff  = shl - dsr_q;
  assign rem_d = diff[WIDTH] ? shl : diff;
  assign quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fix = q_neg_q ? -quo_d : quo_d;
  assign r_fix = r_neg_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ans_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == CALC) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          ans_q   <= zero_q ? {{WIDTH{1'b1}}, dvd_q} : {q_fix, r_fix};
          dz_q    <= zero_q;
        end
      end else if (start_i) begin
        // IDLE and DONE both accept, giving back-to-back operation from DONE
        state_q <= CALC;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= dvd_mag;
        dsr_q   <= {1'b0, dsr_mag};
        dvd_q   <= dividend_i;
        q_neg_q <= is_signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
        r_neg_q <= is_signed_i & dividend_i[WIDTH-1];
        zero_q  <= divisor_i == '0;
      end else begin
        state_q <= IDLE;
      end
    end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_ans_o     = ans_q;
  assign div_by_zero_o = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider against an arithmetic reference model
module tb_seq_divider;
  logic        clk = 1'b0, reset, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, dz;
  logic [63:0] ans;
  seq_divider #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .is_signed_i(is_signed),
    .dividend_i(dividend), .divisor_i(divisor), .busy_o(busy), .done_o(done),
    .div_ans_o(ans), .div_by_zero_o(dz)
  );
  always #5 clk = ~clk;
  typedef struct {logic [63:0] ans; logic dz; int cyc;} exp_t;
  exp_t        sb[$];
  exp_t        me;
  int          checks = 0, failures = 0, cyc = 0, busy_cnt = 0, last_done = 0, prev_done = 0;
  logic        prev_lvl = 1'b0, last_dz = 1'b0;
  logic [63:0] last_ans = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 0) return {1'b1, 32'hFFFFFFFF, a};
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
    end
    return {1'b0, q[31:0], r[31:0]};
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] sp [4] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
    case ($urandom_range(0, 4))
      0:       return sp[$urandom_range(0, 3)];
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  // monitor: every done pops one expected result
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      prev_lvl = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        chk("done_width", 64'(prev_lvl), 64'd0);
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("busy_in_done", 64'(busy), 64'd0);
        busy_cnt = 0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done act=%h exp=none", ans);
        end else begin
          me = sb.pop_front();
          chk("div_ans", ans, me.ans);
          chk("div_by_zero", 64'(dz), 64'(me.dz));
          chk("latency", 64'(cyc - me.cyc), 64'd32);
          last_ans = me.ans;
          last_dz  = me.dz;
        end
        prev_done = last_done;
        last_done = cyc;
      end
      prev_lvl = done;
    end
  end
  // holds start high (operands fixed) until the DUT accepts it
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ea, input logic ed);
    int   n = 0;
    exp_t e;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout busy=%b exp=0", busy);
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.ans = ea;
    e.dz  = ed;
    e.cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
  endtask
  task automatic issue_rand();
    logic        s;
    logic [31:0] a, b;
    logic [64:0] m;
    s = 1'($urandom_range(0, 1));
    a = rnd();
    b = rnd();
    m = model(s, a, b);
    issue(s, a, b, m[63:0], m[64]);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ans", ans, 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    // unsigned basic, with ignored start pulses at op cycles 5 and 20
    issue(1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, 1'b0);
    repeat (4) @(negedge clk);
    dividend = 32'd77; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    dividend = 32'd50; divisor = 32'd0; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_ans", ans, last_ans);
    chk("hold_dz", 64'(dz), 64'(last_dz));
    // signed sign combinations
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 1'b0);
    chk("hold_on_start", ans, last_ans);
    issue(1'b1, 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 1'b0);
    issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'h00000003_FFFFFFFF, 1'b0);
    // overflow edge
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1'b0);
    issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    // divide by zero, then a valid divide clears the flag
    issue(1'b0, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, 1'b1);
    issue(1'b1, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, 1'b1);
    drain();
    issue(1'b0, 32'd9, 32'd3, 64'h00000003_00000000, 1'b0);
    chk("dz_hold_while_busy", 64'(dz), 64'd1);
    drain();
    // start held high through DONE: accepted on the DONE edge
    issue(1'b0, 32'd1234, 32'd5, 64'h000000F6_00000004, 1'b0);
    repeat (10) @(negedge clk);
    issue(1'b1, 32'hFFFFFB2E, 32'd5, 64'hFFFFFF0A_FFFFFFFC, 1'b0);
    drain();
    chk("b2b_gap", 64'(last_done - prev_done), 64'd33);
    // asynchronous reset mid-operation
    issue(1'b0, 32'd1000, 32'd3, 64'h0000014D_00000001, 1'b0);
    repeat (16) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_ans", ans, 64'd0);
    chk("async_rst_dz", 64'(dz), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0FFFFFFF_0000000F, 1'b0);
    drain();
    // randomized traffic, mixing idle gaps with back-to-back requests
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_rand();
    end
    drain();
    repeat (40) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
